max_pool_seq: RTL

// - Streaming max-pool sequencer: folds a window of 8-bit activations into max + argmax

---
 rtl/max_pool_seq_pkg.sv | 12 +
 rtl/max_pool_seq_if.sv | 28 ++
 rtl/max_pool_seq_sort_xy.sv | 15 +
 rtl/max_pool_seq.sv | 120 ++++++++++++
 4 files changed

// File: rtl/max_pool_seq_pkg.sv
// Shared definitions for the streaming max-pool sequencer.
package max_pool_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage : max_pool_pkg

// File: rtl/max_pool_seq_if.sv
// Activation-in / pooled-result-out handshake bundle for max_pool_seq.
interface max_pool_seq_if
    import max_pool_pkg::*;
#(
    parameter int IDX_W = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [IDX_W-1:0]  out_idx;

    // Stream source / result sink side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx
    );

    // Pooling block side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx
    );

endinterface : max_pool_seq_if

// File: rtl/max_pool_seq_sort_xy.sv
// Unsigned two-operand comparator; returns the larger operand.
module sort_xy
    import max_pool_pkg::*;
(
    input  logic [DATA_W-1:0] num1,
    input  logic [DATA_W-1:0] num2,
    output logic [DATA_W-1:0] big
);

    // Pure select, ties resolve to num2 (the value already held)
    always_comb begin
        big = (num1 > num2) ? num1 : num2;
    end

endmodule : sort_xy

// File: rtl/max_pool_seq.sv
// Streaming max-pool sequencer: folds one window of activations into
// its maximum and the position of the first occurrence of that maximum.
module max_pool_seq
    import max_pool_pkg::*;
#(
    parameter int MAX_WIN = 16,
    parameter int IDX_W   = $clog2(MAX_WIN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [IDX_W:0]  cfg_win_len,
    max_pool_seq_if.slave   bus,
    output logic            busy
);

    localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(MAX_WIN);

    state_e            state_q, state_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [IDX_W:0]    len_q, len_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    effLen;
    logic [DATA_W-1:0] sortBig;
    logic              beat;

    assign beat = bus.in_valid & bus.in_ready;

    // Shared comparator: incoming element against the running maximum
    sort_xy u_sort (
        .num1 (bus.in_data),
        .num2 (max_q),
        .big  (sortBig)
    );

    // Clamp the requested window length into 1..MAX_WIN
    always_comb begin
        effLen = cfg_win_len;
        if (cfg_win_len == '0) begin
            effLen = {{IDX_W{1'b0}}, 1'b1};
        end else if (cfg_win_len > MAX_LEN) begin
            effLen = MAX_LEN;
        end
    end

    // Next-state and datapath update; flush overrides any handshake this cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        max_d   = max_q;
        idx_d   = idx_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (beat) begin
                        max_d   = bus.in_data;
                        idx_d   = '0;
                        cnt_d   = {{IDX_W{1'b0}}, 1'b1};
                        len_d   = effLen;
                        state_d = (effLen == {{IDX_W{1'b0}}, 1'b1}) ? OUT : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        max_d = sortBig;
                        if (bus.in_data > max_q) begin
                            idx_d = cnt_q[IDX_W-1:0];
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == len_q - 1'b1) begin
                            state_d = OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.in_ready  = (state_q != OUT);
        bus.out_valid = (state_q == OUT);
        bus.out_max   = max_q;
        bus.out_idx   = idx_q;
        busy          = (state_q != IDLE);
    end

endmodule : max_pool_seq
